smart_light_ctrl_mc: RTL and testbench
======================================

// Module: smart_light_ctrl_mc
// PURPOSE
//  Multi-channel lighting controller; N_CH independent lamp FSMs with AUTO/MANUAL modes.
//  Adds button edge detection, a presence hold timer, a global all-off and a lamp-on count.
//  Sits between the synchronised button/sensor inputs and the lamp drivers and status LEDs.
// PARAMETERS
//  N_CH            4     number of lamp channels (>=1)
//  HOLD_CYC        1000  cycles an AUTO lamp stays on after its sensor drops (>=0)
//  MAN_TIMEOUT_CYC 60000 idle cycles before MANUAL reverts to AUTO (used only with SLC_MAN_TIMEOUT_EN)
// PORTS
//  clk         in   1                  system clock
//  rst         in   1                  synchronous active-high reset
//  btn_mode    in   N_CH               mode button per channel, level, pre-synchronised
//  btn_light   in   N_CH               light toggle button per channel, level, pre-synchronised
//  sensor      in   N_CH               presence&dark sensor per channel, level (1 = want light)
//  all_off     in   1                  global off request, level, sampled every cycle
//  lamp        out  N_CH               lamp drive (1 = on)
//  manual      out  N_CH               manual-mode indicator LED
//  auto_on     out  N_CH               1 when the channel is AUTO and its lamp is on
//  lamps_on    out  $clog2(N_CH+1)     registered count of lamps that are on
// BEHAVIOUR
//  - One clock, clk; rst is synchronous, active-high; all state is updated on posedge clk only.
//  - Per-channel states: AUTO_OFF, AUTO_ON, MAN_OFF, MAN_ON. Outputs are decoded from the registered state:
//    lamp=ON states; manual=MAN_*; auto_on=AUTO_ON. Events take effect at the edge that samples them.
//  - Edge detect: rise = btn & ~btn_q; btn_q registers reset to 1 (a button held through reset is not an edge).
//  - Per-channel priority, highest first: all_off > mode rise > light rise > sensor/timer.
//    all_off=1           : any state -> MAN_OFF
//    mode rise           : AUTO_* -> MAN_OFF; MAN_* -> AUTO_ON if sensor=1 (hold_cnt<=HOLD_CYC), else AUTO_OFF
//    light rise (MAN_*)  : MAN_OFF <-> MAN_ON; ignored in AUTO_*
//    AUTO_OFF, sensor=1  : -> AUTO_ON, hold_cnt<=HOLD_CYC
//    AUTO_ON,  sensor=1  : hold_cnt<=HOLD_CYC (reload)
//    AUTO_ON,  sensor=0  : hold_cnt!=0 -> hold_cnt-1; hold_cnt==0 -> AUTO_OFF
//  - Hold: lamp stays on for exactly HOLD_CYC sensor-low samples; off at the (HOLD_CYC+1)th consecutive low.
//    HOLD_CYC=0: lamp goes off at the first low sample.
//  - hold_cnt is $clog2(HOLD_CYC+1) bits wide (min 1); it never wraps (saturates at 0, reload caps at HOLD_CYC).
//  - Simultaneous mode and light rise: mode wins; light rise is discarded (not deferred).
//  - lamps_on = popcount(lamp), registered: one cycle behind lamp. Max N_CH, no overflow.
//  - Reset (any cycle, mid-count included): state=AUTO_OFF; hold_cnt=0; btn_q=1; lamp=manual=auto_on=0; lamps_on=0.
//  - Channels are fully independent except all_off and lamps_on.
// CONFIGURATION
//  SLC_MAN_TIMEOUT_EN defined: per-channel idle counter, $clog2(MAN_TIMEOUT_CYC+1) bits, cleared on entry to MAN_*
//    and on any btn_light rise; increments each cycle in MAN_*. At count==MAN_TIMEOUT_CYC-1 the channel
//    leaves MAN_* for AUTO_ON/AUTO_OFF per sensor, exactly as a mode rise would, unless a higher-priority
//    event occurs in the same cycle. Held at 0 in AUTO_*. all_off entry to MAN_OFF clears and restarts it.
//  SLC_MAN_TIMEOUT_EN undefined: no idle counter; MANUAL persists until mode rise or reset; MAN_TIMEOUT_CYC unused.
// TESTING
//  1 Reset with btn_mode[0] held 1 -> no transition after release of rst; all outputs 0; lamps_on=0.
//  2 ch0 sensor 1 for 1 cycle then 0, HOLD_CYC=3 -> lamp[0]=1 for 4 cycles (1 sensor-high + 3 hold samples), then 0.
//  3 ch1 btn_mode rise -> manual[1]=1, lamp[1]=0; btn_light rise x2 -> lamp[1] 1 then 0; 2nd mode rise, sensor=1 -> AUTO_ON.
//  4 ch2 btn_mode and btn_light rise in same cycle from MAN_OFF -> AUTO_*; lamp follows sensor, no toggle.
//  5 all ch AUTO_ON, all_off=1 one cycle -> all MAN_OFF; lamps_on 4 -> 0 one cycle after lamp drops.
//  6 SLC_MAN_TIMEOUT_EN, MAN_TIMEOUT_CYC=8, ch3 MAN_ON idle, sensor=0 -> AUTO_OFF 8 cycles after entering MAN_ON; light rise at cycle 5 restarts count.

Source files
------------

// File: rtl/smart_light_ctrl_mc.sv
// ---------------------------------------------------------------------------
// smart_light_ctrl_mc
//
// Multi-channel lighting controller. Each of the N_CH channels runs its own
// four-state lamp FSM (AUTO_OFF, AUTO_ON, MAN_OFF, MAN_ON). Mode and light
// buttons are edge-detected, a presence hold timer keeps AUTO lamps lit for
// HOLD_CYC cycles after their sensor drops, a global all-off forces every
// channel into MAN_OFF, and a registered count of lit lamps is provided.
//
// Optional feature macro: SLC_MAN_TIMEOUT_EN
//   When defined, a channel left idle in MANUAL for MAN_TIMEOUT_CYC cycles
//   reverts to AUTO as if its mode button had been pressed.
//
// Ports
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   btn_mode_i    per-channel mode button (level, pre-synchronised)
//   btn_light_i   per-channel light toggle button (level, pre-synchronised)
//   sensor_i      per-channel presence&dark sensor (1 = want light)
//   all_off_i     global off request, sampled every cycle
//   lamp_o        per-channel lamp drive (1 = on)
//   manual_o      per-channel manual-mode indicator
//   auto_on_o     per-channel "AUTO and lamp on" indicator
//   lamps_on_o    registered count of lit lamps, one cycle behind lamp_o
// ---------------------------------------------------------------------------
module smart_light_ctrl_mc #(
    parameter int N_CH            = 4,
    parameter int HOLD_CYC        = 1000,
    parameter int MAN_TIMEOUT_CYC = 60000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_CH-1:0]             btn_mode_i,
    input  logic [N_CH-1:0]             btn_light_i,
    input  logic [N_CH-1:0]             sensor_i,
    input  logic                        all_off_i,
    output logic [N_CH-1:0]             lamp_o,
    output logic [N_CH-1:0]             manual_o,
    output logic [N_CH-1:0]             auto_on_o,
    output logic [$clog2(N_CH+1)-1:0]   lamps_on_o
);

    localparam int CW = $clog2(N_CH + 1);
    localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC);

    typedef enum logic [1:0] {
        AUTO_OFF = 2'd0,
        AUTO_ON  = 2'd1,
        MAN_OFF  = 2'd2,
        MAN_ON   = 2'd3
    } state_e;

    state_e            state_q [N_CH];
    state_e            state_d [N_CH];
    logic [HW-1:0]     hold_q  [N_CH];
    logic [HW-1:0]     hold_d  [N_CH];
    logic [N_CH-1:0]   btnMode_q;
    logic [N_CH-1:0]   btnLight_q;
    logic [N_CH-1:0]   modeRise;
    logic [N_CH-1:0]   lightRise;
    logic [N_CH-1:0]   lamp_q;
    logic [N_CH-1:0]   manual_q;
    logic [N_CH-1:0]   autoOn_q;
    logic [CW-1:0]     lampsOn_q;
    logic [CW-1:0]     lampCount;

`ifdef SLC_MAN_TIMEOUT_EN
    localparam int IW = (MAN_TIMEOUT_CYC > 0) ? $clog2(MAN_TIMEOUT_CYC + 1) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(MAN_TIMEOUT_CYC - 1);

    logic [IW-1:0]     idle_q  [N_CH];
    logic [IW-1:0]     idle_d  [N_CH];
`endif

    // The button history registers reset to 1, so a button already held
    // down when reset releases is not mistaken for a fresh press.
    assign modeRise  = btn_mode_i  & ~btnMode_q;
    assign lightRise = btn_light_i & ~btnLight_q;

    // Next-state logic for every channel. Priority, highest first:
    // all-off, mode press, light press, then sensor / hold / idle timing.
    // A light press arriving together with a mode press is simply dropped.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
`ifdef SLC_MAN_TIMEOUT_EN
            idle_d[i]  = '0;
`endif
            if (all_off_i) begin
                state_d[i] = MAN_OFF;
                hold_d[i]  = '0;
            end else if (modeRise[i]) begin
                if (state_q[i] == AUTO_OFF || state_q[i] == AUTO_ON) begin
                    state_d[i] = MAN_OFF;
                    hold_d[i]  = '0;
                end else if (sensor_i[i]) begin
                    state_d[i] = AUTO_ON;
                    hold_d[i]  = HOLD_LD;
                end else begin
                    state_d[i] = AUTO_OFF;
                    hold_d[i]  = '0;
                end
            end else begin
                case (state_q[i])
                    AUTO_OFF: begin
                        if (sensor_i[i]) begin
                            state_d[i] = AUTO_ON;
                            hold_d[i]  = HOLD_LD;
                        end
                    end
                    AUTO_ON: begin
                        // Counter only counts down while the sensor is low
                        // and turns the lamp off once it has reached zero.
                        if (sensor_i[i]) begin
                            hold_d[i] = HOLD_LD;
                        end else if (hold_q[i] != '0) begin
                            hold_d[i] = hold_q[i] - 1'b1;
                        end else begin
                            state_d[i] = AUTO_OFF;
                        end
                    end
                    default: begin
                        if (lightRise[i]) begin
                            state_d[i] = (state_q[i] == MAN_ON) ? MAN_OFF : MAN_ON;
`ifdef SLC_MAN_TIMEOUT_EN
                        end else if (idle_q[i] == IDLE_LAST) begin
                            // Idle too long: leave MANUAL exactly like a mode press.
                            if (sensor_i[i]) begin
                                state_d[i] = AUTO_ON;
                                hold_d[i]  = HOLD_LD;
                            end else begin
                                state_d[i] = AUTO_OFF;
                                hold_d[i]  = '0;
                            end
                        end else begin
                            idle_d[i] = idle_q[i] + 1'b1;
`endif
                        end
                    end
                endcase
            end
        end
    end

    // Population count of the lamp register feeding the registered total.
    always_comb begin
        lampCount = '0;
        for (int i = 0; i < N_CH; i++) begin
            lampCount = lampCount + CW'(lamp_q[i]);
        end
    end

    // All state lives here. The per-channel outputs are registered copies of
    // the next-state decode, so they always agree with state_q, while
    // lampsOn_q counts the already-registered lamps and lags by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= AUTO_OFF;
                hold_q[i]  <= '0;
`ifdef SLC_MAN_TIMEOUT_EN
                idle_q[i]  <= '0;
`endif
            end
            btnMode_q  <= '1;
            btnLight_q <= '1;
            lamp_q     <= '0;
            manual_q   <= '0;
            autoOn_q   <= '0;
            lampsOn_q  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= state_d[i];
                hold_q[i]   <= hold_d[i];
`ifdef SLC_MAN_TIMEOUT_EN
                idle_q[i]   <= idle_d[i];
`endif
                lamp_q[i]   <= (state_d[i] == AUTO_ON) || (state_d[i] == MAN_ON);
                manual_q[i] <= (state_d[i] == MAN_OFF) || (state_d[i] == MAN_ON);
                autoOn_q[i] <= (state_d[i] == AUTO_ON);
            end
            btnMode_q  <= btn_mode_i;
            btnLight_q <= btn_light_i;
            lampsOn_q  <= lampCount;
        end
    end

    assign lamp_o     = lamp_q;
    assign manual_o   = manual_q;
    assign auto_on_o  = autoOn_q;
    assign lamps_on_o = lampsOn_q;

endmodule

// File: tb/tb_smart_light_ctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_smart_light_ctrl_mc
//
// Directed bench for smart_light_ctrl_mc with N_CH=4, HOLD_CYC=3 and
// MAN_TIMEOUT_CYC=8. Each stimulus step queues the outputs expected after
// the next clock edge; an independent monitor pops one entry per edge and
// compares. The idle-timeout scenario is only exercised when
// SLC_MAN_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_smart_light_ctrl_mc;

    localparam int N_CH            = 4;
    localparam int HOLD_CYC        = 3;
    localparam int MAN_TIMEOUT_CYC = 8;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [3:0] btnMode  = 4'b0000;
    logic [3:0] btnLight = 4'b0000;
    logic [3:0] sensor   = 4'b0000;
    logic       allOff   = 1'b0;
    logic [3:0] lamp;
    logic [3:0] manual;
    logic [3:0] autoOn;
    logic [2:0] lampsOn;

    typedef struct {
        logic [3:0] lamp;
        logic [3:0] man;
        logic [3:0] autoOn;
        logic [2:0] lampsOn;
        string      name;
    } exp_t;

    exp_t       expQ[$];
    int         total    = 0;
    int         bad      = 0;
    logic [3:0] lastLamp = 4'b0000;

    smart_light_ctrl_mc #(
        .N_CH            (N_CH),
        .HOLD_CYC        (HOLD_CYC),
        .MAN_TIMEOUT_CYC (MAN_TIMEOUT_CYC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_mode_i  (btnMode),
        .btn_light_i (btnLight),
        .sensor_i    (sensor),
        .all_off_i   (allOff),
        .lamp_o      (lamp),
        .manual_o    (manual),
        .auto_on_o   (autoOn),
        .lamps_on_o  (lampsOn)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue the outputs
    // expected after the following rising edge. The lamp count expected is
    // the number of lamps lit in the previous step.
    task automatic applyStimulus(input logic r, input logic [3:0] m, input logic [3:0] l,
                                 input logic [3:0] s, input logic ao,
                                 input logic [3:0] eLamp, input logic [3:0] eMan,
                                 input string name);
        exp_t e;
        @(negedge clk);
        rst      = r;
        btnMode  = m;
        btnLight = l;
        sensor   = s;
        allOff   = ao;
        e.lamp    = eLamp;
        e.man     = eMan;
        e.autoOn  = eLamp & ~eMan;
        e.lampsOn = r ? 3'd0 : 3'($countones(lastLamp));
        e.name    = name;
        lastLamp  = eLamp;
        expQ.push_back(e);
    endtask

    task automatic applyRepeat(input int n, input logic [3:0] m, input logic [3:0] l,
                               input logic [3:0] s, input logic ao,
                               input logic [3:0] eLamp, input logic [3:0] eMan,
                               input string name);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, m, l, s, ao, eLamp, eMan, name);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        total++;
        if (lamp !== e.lamp || manual !== e.man || autoOn !== e.autoOn || lampsOn !== e.lampsOn) begin
            bad++;
            $display("[TB] FAIL %s: got lamp=%b manual=%b auto_on=%b lamps_on=%0d, want lamp=%b manual=%b auto_on=%b lamps_on=%0d",
                     e.name, lamp, manual, autoOn, lampsOn, e.lamp, e.man, e.autoOn, e.lampsOn);
        end
    endtask

    // Monitor: one expectation is consumed per rising edge, sampled just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with ch0 mode button held: no edge after release.
        applyStimulus(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, "reset_held_btn");
        applyStimulus(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, "reset_held_btn2");
        applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, "release_no_edge");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, "btn_release");

        // ch0 hold timer: one sensor-high sample plus three hold samples.
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b0001, 4'b0000, "hold_on");
        applyRepeat(3, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, "hold_count");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, "hold_off");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, "hold_stay_off");

        // ch0 hold reload: sensor returns mid-countdown.
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b0001, 4'b0000, "reload_on");
        applyRepeat(2, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, "reload_count");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b0001, 4'b0000, "reload_again");
        applyRepeat(3, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, "reload_hold");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, "reload_off");

        // ch1 manual mode and light toggling, then back to AUTO with sensor high.
        applyStimulus(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010, "ch1_to_manual");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010, "ch1_manual_idle");
        applyStimulus(1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, "ch1_light_on");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, "ch1_light_hold");
        applyStimulus(1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, "ch1_light_off");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010, "ch1_light_rel");
        applyStimulus(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0000, "ch1_to_auto_on");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0000, "ch1_auto_on");
        applyStimulus(1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, "ch1_light_ignored");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0000, "ch1_light_ign_rel");

        // ch2 simultaneous mode and light press: mode wins, no toggle.
        applyStimulus(1'b0, 4'b0100, 4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0100, "ch2_to_manual");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0100, "ch2_manual_idle");
        applyStimulus(1'b0, 4'b0100, 4'b0100, 4'b0110, 1'b0, 4'b0110, 4'b0000, "ch2_both_sens1");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0110, 1'b0, 4'b0110, 4'b0000, "ch2_auto_on");
        applyStimulus(1'b0, 4'b0100, 4'b0000, 4'b0110, 1'b0, 4'b0010, 4'b0100, "ch2_on_to_manual");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0100, "ch2_manual_idle2");
        applyStimulus(1'b0, 4'b0100, 4'b0100, 4'b0010, 1'b0, 4'b0010, 4'b0000, "ch2_both_sens0");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0000, "ch2_auto_off");

        // All channels lit, then global all-off; lamp count trails by a cycle.
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b0000, "all_auto_on");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b0000, "all_count4");
        applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b1111, 1'b0, 4'b1110, 4'b0001, "ch0_on_to_manual");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b1110, 4'b0001, "ch0_manual_off");
        applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b0000, "ch0_back_auto");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b0000, "all_on_again");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111, "all_off");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b1111, "all_off_count0");
        applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111, "all_off_beats_mode");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, "manual_persist");
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, "all_to_auto_off");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, "all_auto_idle");

`ifdef SLC_MAN_TIMEOUT_EN
        // ch3 idle timeout from MAN_ON.
        applyStimulus(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1000, "to_ch3_manual");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1000, "to_ch3_idle");
        applyStimulus(1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b1000, "to_ch3_man_on");
        applyRepeat(7, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b1000, 4'b1000, "to_ch3_waiting");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, "to_ch3_expired");

        // Light press at cycle 5 restarts the idle count.
        applyStimulus(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1000, "tr_ch3_manual");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1000, "tr_ch3_idle");
        applyStimulus(1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b1000, "tr_ch3_man_on");
        applyRepeat(4, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b1000, 4'b1000, "tr_ch3_wait1");
        applyStimulus(1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b1000, "tr_ch3_restart");
        applyRepeat(7, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1000, "tr_ch3_wait2");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, "tr_ch3_expired");
`endif

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int k = 0; k < 5 && expQ.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
